// File: rtl/adc_uart_pkg.sv
// Shared definitions for the ADC-to-UART packet transmitter.
// Build option: define ADC_UART_CHECKSUM_EN to append an XOR checksum byte
// (byte1 ^ byte2 ^ byte3) to every packet, giving 5 bytes instead of 4.
package adc_uart_pkg;

   // First byte of every packet, lets the PC resynchronise on the stream.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Width of the ADC word the packet layout is built around.
   localparam int ADC_W = 18;

`ifdef ADC_UART_CHECKSUM_EN
   localparam int PKT_BYTES = 5;
`else
   localparam int PKT_BYTES = 4;
`endif

   // Framing FSM states; NEXT is the final cycle of each stop bit.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      NEXT  = 3'd5
   } tx_state_t;

   // Returns byte number idx of the packet carrying word.
   function automatic logic [7:0] pkt_byte(input logic [ADC_W-1:0] word,
                                           input logic [2:0]       idx);
      logic [7:0] b;
      b = SYNC_BYTE;
      case (idx)
         3'd1:    b = {6'b0, word[17:16]};
         3'd2:    b = word[15:8];
         3'd3:    b = word[7:0];
`ifdef ADC_UART_CHECKSUM_EN
         3'd4:    b = {6'b0, word[17:16]} ^ word[15:8] ^ word[7:0];
`endif
         default: b = SYNC_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/adc_word_fifo.sv
// Small synchronous FIFO holding ADC words waiting for the UART.
// full/empty are registered so they are clean to use as FSM and status inputs.
// A write while full is only accepted when a read happens in the same cycle.
module adc_word_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             do_wr;
   logic             do_rd;

   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   // Occupancy after this cycle's push/pop, used to register full/empty.
   always_comb begin
      count_next = count;
      case ({do_wr, do_rd})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage array; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and registered flags.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/adc_uart_tx.sv
// ADC word to UART packet transmitter (8N1, idle high).
// Each queued ADC word is sent as SYNC_BYTE followed by the word split into
// bytes, MSB byte first; with ADC_UART_CHECKSUM_EN defined a trailing XOR
// checksum byte is added.
// adc_valid is a push-only strobe with no back-pressure: a word arriving while
// the FIFO is full (and not popping that cycle) is dropped and overflow sticks.
module adc_uart_tx
   import adc_uart_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int ADC_BITS   = 18,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk_ext,
   input  logic                rstb_ext,
   input  logic                adc_valid,
   input  logic [ADC_BITS-1:0] adc_data,
   output logic                uart_txd,
   output logic                busy,
   output logic                fifo_full,
   output logic                overflow,
   output tx_state_t           fsm_state
);

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   // STOP is one cycle short because NEXT supplies the last stop-bit cycle,
   // keeping every byte exactly 10 * CLK_DIV cycles long.
   localparam logic [15:0] STOP_LAST = 16'(CLK_DIV - 2);
   localparam logic [2:0]  LAST_BYTE = 3'(PKT_BYTES - 1);

   tx_state_t           state;
   logic [15:0]         cnt;
   logic [2:0]          bit_idx;
   logic [2:0]          byte_idx;
   logic [7:0]          tx_byte;
   logic [ADC_BITS-1:0] word_q;

   logic                fifo_empty;
   logic                pop;
   logic                push;
   logic [ADC_BITS-1:0] fifo_word;

   assign pop       = (state == LOAD);
   assign push      = adc_valid && (!fifo_full || pop);
   assign busy      = (state != IDLE) || !fifo_empty;
   assign fsm_state = state;

   adc_word_fifo #(
      .WIDTH (ADC_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_ext),
      .rstb    (rstb_ext),
      .wr_en   (push),
      .wr_data (adc_data),
      .rd_en   (pop),
      .rd_data (fifo_word),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sticky drop flag: set when a word arrives with no room for it.
   always_ff @(posedge clk_ext or negedge rstb_ext) begin
      if (!rstb_ext) begin
         overflow <= 1'b0;
      end else if (adc_valid && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   // Framing FSM with baud counter and registered serial output.
   always_ff @(posedge clk_ext or negedge rstb_ext) begin
      if (!rstb_ext) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         tx_byte  <= '0;
         word_q   <= '0;
         uart_txd <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               uart_txd <= 1'b1;
               if (!fifo_empty) state <= LOAD;
            end
            LOAD: begin
               word_q   <= fifo_word;
               byte_idx <= '0;
               bit_idx  <= '0;
               cnt      <= '0;
               tx_byte  <= pkt_byte(fifo_word, 3'd0);
               uart_txd <= 1'b0;
               state    <= START;
            end
            START: begin
               if (cnt == DIV_LAST) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  uart_txd <= tx_byte[0];
                  state    <= DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx  <= '0;
                     uart_txd <= 1'b1;
                     state    <= STOP;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     uart_txd <= tx_byte[1];
                     tx_byte  <= {1'b1, tx_byte[7:1]};
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (cnt == STOP_LAST) begin
                  cnt   <= '0;
                  state <= NEXT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            NEXT: begin
               if (byte_idx == LAST_BYTE) begin
                  byte_idx <= '0;
                  state    <= IDLE;
               end else begin
                  byte_idx <= byte_idx + 3'd1;
                  tx_byte  <= pkt_byte(word_q, byte_idx + 3'd1);
                  uart_txd <= 1'b0;
                  state    <= START;
               end
            end
            default: begin
               uart_txd <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_uart_tx.sv
// Self-checking bench for adc_uart_tx at CLK_DIV=4, FIFO_DEPTH=4.
// Honours ADC_UART_CHECKSUM_EN when defined (5-byte packets, checksum tests).
module tb_adc_uart_tx;
   import adc_uart_pkg::*;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
`ifdef ADC_UART_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   typedef logic [7:0] pkt_t [5];

   logic        clk_ext   = 1'b0;
   logic        rstb_ext  = 1'b0;
   logic        adc_valid = 1'b0;
   logic [17:0] adc_data  = '0;
   logic        uart_txd;
   logic        busy;
   logic        fifo_full;
   logic        overflow;
   tx_state_t   fsm_state;

   int checks = 0;
   int passed = 0;

   // Clock and watchdog
   always #5 clk_ext = ~clk_ext;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   adc_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .ADC_BITS   (18),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_ext   (clk_ext),
      .rstb_ext  (rstb_ext),
      .adc_valid (adc_valid),
      .adc_data  (adc_data),
      .uart_txd  (uart_txd),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .fsm_state (fsm_state)
   );

   // Reference packet built from the packet layout.
   function automatic pkt_t model_pkt(input logic [17:0] w);
      pkt_t p;
      p[0] = 8'hA5;
      p[1] = {6'b0, w[17:16]};
      p[2] = w[15:8];
      p[3] = w[7:0];
      p[4] = p[1] ^ p[2] ^ p[3];
      return p;
   endfunction

   // Driver tasks: all called on a negedge, return on a negedge.
   task automatic do_reset();
      @(negedge clk_ext);
      rstb_ext = 1'b0;
      repeat (3) @(negedge clk_ext);
      rstb_ext = 1'b1;
      @(negedge clk_ext);
   endtask

   task automatic push_word(input logic [17:0] w);
      adc_valid = 1'b1;
      adc_data  = w;
      @(negedge clk_ext);
      adc_valid = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (uart_txd !== 1'b0 && n < 200) begin
         @(negedge clk_ext);
         n++;
      end
      if (uart_txd !== 1'b0) begin
         checks++;
         $display("FAIL %s: no start bit within 200 cycles, line=%b required 0", name, uart_txd);
      end
   endtask

   // Compares the line, every cycle, against the expected frames; the caller
   // is positioned on the first start-bit sample.
   task automatic check_packet(input pkt_t eb, input string name);
      logic [9:0] frame;
      logic [9:0] obs;
      logic       bad;
      for (int b = 0; b < NB; b++) begin
         frame = {1'b1, eb[b], 1'b0};
         obs   = '0;
         bad   = 1'b0;
         for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < CLK_DIV; s++) begin
               if (uart_txd !== frame[i]) bad = 1'b1;
               if (s == CLK_DIV / 2) obs[i] = uart_txd;
               @(negedge clk_ext);
            end
         end
         checks++;
         if (bad || obs !== frame)
            $display("FAIL %s byte%0d: line carried %h (frame %b, timing %s), required %h",
                     name, b, obs[8:1], obs, bad ? "wrong" : "ok", eb[b]);
         else
            passed++;
      end
   endtask

   task automatic test_reset();
      rstb_ext = 1'b0;
      repeat (3) @(negedge clk_ext);
      checks++; if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b required 1", uart_txd); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
      checks++; if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b required 0", fifo_full); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else passed++;
      checks++; if (fsm_state !== IDLE) $display("FAIL reset_state: got %0d required %0d", fsm_state, IDLE); else passed++;
      rstb_ext = 1'b1;
      @(negedge clk_ext);
   endtask

   task automatic test_single();
      pkt_t e;
      int   lat;
      e[0] = 8'hA5; e[1] = 8'h02; e[2] = 8'hAB; e[3] = 8'hCD; e[4] = 8'h64;
      do_reset();
      push_word(18'h2ABCD);
      lat = 0;
      while (uart_txd !== 1'b0 && lat < 50) begin
         @(negedge clk_ext);
         lat++;
      end
      checks++; if (lat !== 2) $display("FAIL single_latency: got %0d cycles required 2", lat); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL single_busy_tx: got %b required 1", busy); else passed++;
      check_packet(e, "single");
      checks++;
      if (uart_txd !== 1'b1 || busy !== 1'b0)
         $display("FAIL single_end: txd=%b busy=%b required txd=1 busy=0", uart_txd, busy);
      else passed++;
   endtask

`ifdef ADC_UART_CHECKSUM_EN
   task automatic test_checksum();
      pkt_t e;
      do_reset();
      e[0] = 8'hA5; e[1] = 8'h03; e[2] = 8'hFF; e[3] = 8'hFF; e[4] = 8'h03;
      push_word(18'h3FFFF);
      wait_start("csum_neg1");
      check_packet(e, "csum_neg1");
      checks++; if (busy !== 1'b0) $display("FAIL csum_neg1_busy: got %b required 0", busy); else passed++;
      e[0] = 8'hA5; e[1] = 8'h02; e[2] = 8'hAB; e[3] = 8'hCD; e[4] = 8'h64;
      push_word(18'h2ABCD);
      wait_start("csum_2abcd");
      check_packet(e, "csum_2abcd");
   endtask
`endif

   task automatic test_overflow();
      logic [17:0] ws [6];
      pkt_t        e;
      logic        quiet;
      ws[0] = 18'h30001; ws[1] = 18'h28000; ws[2] = 18'h17F7F;
      ws[3] = 18'h000FF; ws[4] = 18'h3DEAD; ws[5] = 18'h2BEEF;
      do_reset();
      push_word(18'h01111);
      fork
         begin
            pkt_t e0;
            e0 = model_pkt(18'h01111);
            wait_start("ovf_first");
            check_packet(e0, "ovf_first");
         end
         begin
            repeat (10) @(negedge clk_ext);
            for (int k = 0; k < 6; k++) push_word(ws[k]);
            checks++; if (fifo_full !== 1'b1) $display("FAIL ovf_full: got %b required 1", fifo_full); else passed++;
            checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b required 1", overflow); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL ovf_busy: got %b required 1", busy); else passed++;
         end
      join
      for (int k = 0; k < 4; k++) begin
         e = model_pkt(ws[k]);
         wait_start("ovf_order");
         check_packet(e, "ovf_order");
      end
      checks++; if (busy !== 1'b0) $display("FAIL ovf_drain_busy: got %b required 0", busy); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow); else passed++;
      checks++; if (fifo_full !== 1'b0) $display("FAIL ovf_drain_full: got %b required 0", fifo_full); else passed++;
      quiet = 1'b1;
      repeat (100) begin
         @(negedge clk_ext);
         if (uart_txd !== 1'b1) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) $display("FAIL ovf_dropped_sent: line active=%b required 0", !quiet); else passed++;
   endtask

   task automatic test_push_pop_full();
      logic [17:0] ws [5];
      pkt_t        e;
      ws[0] = 18'h12345; ws[1] = 18'h0A0A0; ws[2] = 18'h35555;
      ws[3] = 18'h20F0F; ws[4] = 18'h1C3C3;
      do_reset();
      push_word(18'h00042);
      fork
         begin
            pkt_t e0;
            e0 = model_pkt(18'h00042);
            wait_start("pp_first");
            check_packet(e0, "pp_first");
         end
         begin
            repeat (10) @(negedge clk_ext);
            for (int k = 0; k < 4; k++) push_word(ws[k]);
            checks++; if (fifo_full !== 1'b1) $display("FAIL pp_full: got %b required 1", fifo_full); else passed++;
         end
      join
      // Line is now at the end of the first packet's stop bit.
      @(negedge clk_ext);
      checks++; if (fsm_state !== LOAD) $display("FAIL pp_state: got %0d required %0d", fsm_state, LOAD); else passed++;
      push_word(ws[4]);
      checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b required 0", overflow); else passed++;
      checks++; if (fifo_full !== 1'b1) $display("FAIL pp_still_full: got %b required 1", fifo_full); else passed++;
      for (int k = 0; k < 5; k++) begin
         e = model_pkt(ws[k]);
         wait_start("pp_order");
         check_packet(e, "pp_order");
      end
      checks++; if (busy !== 1'b0) $display("FAIL pp_busy_end: got %b required 0", busy); else passed++;
   endtask

   task automatic test_reset_midframe();
      pkt_t e;
      logic quiet;
      do_reset();
      push_word(18'h1F00D);
      wait_start("rst_frame");
      for (int k = 0; k < 5; k++) push_word(18'h00100 + 18'(k));
      checks++; if (overflow !== 1'b1) $display("FAIL rst_pre_overflow: got %b required 1", overflow); else passed++;
      // Sample 97 of the packet: mid data bit 3 of byte2.
      repeat (92) @(negedge clk_ext);
      rstb_ext = 1'b0;
      #1;
      checks++; if (uart_txd !== 1'b1) $display("FAIL rst_mid_txd: got %b required 1", uart_txd); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", busy); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL rst_mid_overflow: got %b required 0", overflow); else passed++;
      checks++; if (fifo_full !== 1'b0) $display("FAIL rst_mid_full: got %b required 0", fifo_full); else passed++;
      checks++; if (fsm_state !== IDLE) $display("FAIL rst_mid_state: got %0d required %0d", fsm_state, IDLE); else passed++;
      repeat (3) @(negedge clk_ext);
      rstb_ext = 1'b1;
      quiet = 1'b1;
      repeat (300) begin
         @(negedge clk_ext);
         if (uart_txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) $display("FAIL rst_quiet: activity=%b required 0", !quiet); else passed++;
      e = model_pkt(18'h00F0F);
      push_word(18'h00F0F);
      wait_start("rst_resume");
      check_packet(e, "rst_resume");
      checks++; if (busy !== 1'b0) $display("FAIL rst_resume_busy: got %b required 0", busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
`ifdef ADC_UART_CHECKSUM_EN
      test_checksum();
`endif
      test_overflow();
      test_push_pop_full();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/adc_uart_tx.md
ADC_UART_TX -- requirements
Module: adc_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, clk_ext cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter ADC_BITS, default 18, width of the signed ADC word; fixed at 18 in this release.
REQ-003 Parameter FIFO_DEPTH, default 4, number of queued ADC words; power of two, 2..16.
REQ-004 clk_ext  input  1  system clock.
REQ-005 rstb_ext  input  1  reset, asynchronous, active-low.
REQ-006 adc_valid  input  1  one-cycle strobe; adc_data is valid this cycle.
REQ-007 adc_data  input  18  signed ADC result from the chip-readout stage.
REQ-008 uart_txd  output  1  UART serial line to the PC, 8N1, idle high.
REQ-009 busy  output  1  high while a packet is being transmitted or the FIFO is non-empty.
REQ-010 fifo_full  output  1  high when FIFO_DEPTH words are queued.
REQ-011 overflow  output  1  sticky flag; a word was dropped.

Function
REQ-012 On an adc_valid cycle with the FIFO not full, the block SHALL push adc_data into the FIFO.
REQ-013 On an adc_valid cycle with the FIFO full and no pop in the same cycle, the block SHALL drop the word and set overflow; overflow then holds until reset.
REQ-014 A push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-015 Packet format: byte0 = 8'hA5 (sync); byte1 = {6'b0, d[17:16]}; byte2 = d[15:8]; byte3 = d[7:0].
REQ-016 Each byte SHALL go out as: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLK_DIV cycles.
REQ-017 FSM states: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE->LOAD when the FIFO is non-empty.
  - LOAD (pop the word, build the packet) -> START.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> NEXT after CLK_DIV cycles.
  - NEXT -> START if bytes remain, else IDLE.
REQ-018 The start bit of byte0 SHALL begin 2 cycles after the FIFO becomes non-empty while the FSM is in IDLE.
REQ-019 NEXT SHALL last exactly one cycle, with uart_txd high.
REQ-020 Bytes of one packet are sent back to back; a new packet never interleaves with the current one.
REQ-021 The bit-period counter and the bit index SHALL wrap to 0 at each bit and byte boundary; there is no cumulative drift.
REQ-022 uart_txd SHALL be registered and glitch-free.

Reset
REQ-023 While rstb_ext=0, regardless of any frame in progress:
  - uart_txd=1, busy=0, fifo_full=0, overflow=0;
  - FIFO empty, FSM in IDLE, all counters 0.
REQ-024 A reset asserted mid-frame SHALL abort the frame; on release, the block SHALL resume only with newly pushed data.

Configuration
REQ-025 Macro ADC_UART_CHECKSUM_EN defined: each packet SHALL carry byte4 = byte1 ^ byte2 ^ byte3 (sync byte excluded), giving 5 bytes per packet.
REQ-026 Macro ADC_UART_CHECKSUM_EN undefined: each packet SHALL be 4 bytes, and no checksum logic is present.

Structure
REQ-027 A shared package adc_uart_pkg SHALL hold: SYNC_BYTE, the FSM state enum, and the PKT_BYTES constant (4 or 5, selected by the macro).
REQ-028 The FIFO SHALL be a sub-module adc_word_fifo (synchronous, registered full/empty); the framing FSM and the baud counter SHALL stay in adc_uart_tx.

Verification
REQ-029 CLK_DIV=4, macro off, single push 18'h2ABCD -> line bytes A5,02,AB,CD; every bit 4 cycles; 160 cycles from the first start bit to the end of the last stop bit; busy then 0.
REQ-030 Macro on, push 18'h3FFFF (-1) -> bytes A5,03,FF,FF,03; 200 cycles at CLK_DIV=4.
REQ-031 Macro on, push 18'h2ABCD -> checksum byte 8'h64.
REQ-032 FIFO_DEPTH=4, with packet 1 already in flight, push 6 words on consecutive cycles -> 4 accepted, 2 dropped, fifo_full=1, overflow=1; the 4 accepted words are later sent in push order.
REQ-033 Assert rstb_ext during bit 3 of byte2 -> uart_txd=1 immediately; no further bytes are sent; overflow=0; busy=0.
REQ-034 Push on the same cycle the FIFO pops with the FIFO full -> both operations succeed and overflow stays 0.
